accu_mc: RTL and testbench

Parametrised multi-channel accumulator with a handshaked input stream and a sequenced dump port. Each input beat carries a channel index and an unsigned operand. The operand is added into, or loaded into, that channel's accumulator. On request, an FSM streams every channel's sum out in order, optionally clearing each channel as it goes. This block is the generalised successor of the single 8-bit accumulator: it adds width and channel parameters, overflow tracking, flow control and readout.

---
 rtl/accu_mc.sv | 130 +++++++++++++
 tb/tb_accu_mc.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/accu_mc.sv
// rtl/accu_mc.sv - multi-channel accumulator with handshaked input stream and sequenced dump port
// Build option: define ACCU_SAT_EN to clamp overflowing adds at 2**ACC_W-1 instead of wrapping.
module accu_mc #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 16,
  parameter int CH_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CH_W-1:0]         in_ch,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    in_clr,
  input  logic                    dump_req,
  input  logic                    dump_clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CH_W-1:0]         out_ch,
  output logic [ACC_W-1:0]        out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic [(2**CH_W)-1:0]    ovf
);

  localparam int CHANNELS = 2 ** CH_W;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_DUMP = 1'b1;

  logic [0:0]          state;
  logic [CH_W-1:0]     idx;
  logic                clr_mode;
  logic [ACC_W-1:0]    acc [CHANNELS];
  logic [CHANNELS-1:0] ovf_q;

  logic                accept;
  logic                take;
  logic                last_idx;
  logic [ACC_W-1:0]    operand;
  logic [ACC_W:0]      sum;
  logic [ACC_W-1:0]    add_res;

  assign in_ready = (state == S_IDLE);
  assign busy     = (state == S_DUMP);
  assign accept   = in_valid && in_ready;
  assign take     = busy && out_ready;
  assign last_idx = &idx;

  always_comb begin
    operand = '0;
    operand[WIDTH-1:0] = in_data;
  end

  // One extra bit captures the carry that feeds the sticky overflow flag.
  assign sum = {1'b0, acc[in_ch]} + {1'b0, operand};

`ifdef ACCU_SAT_EN
  assign add_res = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign add_res = sum[ACC_W-1:0];
`endif

  // Input beats are only accepted in IDLE and dump clears only happen in DUMP,
  // so the two update paths never touch the arrays in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc[i] <= '0;
      end
      ovf_q <= '0;
    end else begin
      if (accept) begin
        if (in_clr) begin
          acc[in_ch]   <= operand;
          ovf_q[in_ch] <= 1'b0;
        end else begin
          acc[in_ch] <= add_res;
          if (sum[ACC_W]) begin
            ovf_q[in_ch] <= 1'b1;
          end
        end
      end
      if (take && clr_mode) begin
        acc[idx]   <= '0;
        ovf_q[idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      clr_mode <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dump_req) begin
            state    <= S_DUMP;
            idx      <= '0;
            clr_mode <= dump_clr;
          end
        end
        S_DUMP: begin
          if (out_ready) begin
            if (last_idx) begin
              state <= S_IDLE;
              idx   <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  // idx is parked at 0 in IDLE, so the readout mux shows acc[0] there.
  assign out_valid = busy;
  assign out_ch    = busy ? idx : '0;
  assign out_data  = acc[out_ch];
  assign out_last  = busy && last_idx;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_accu_mc.sv
// tb/tb_accu_mc.sv - self-checking bench for accu_mc (WIDTH=8, ACC_W=10, CH_W=2)
module tb_accu_mc;

  localparam int WIDTH = 8;
  localparam int ACC_W = 10;
  localparam int CH_W  = 2;
  localparam int NCH   = 4;
  localparam int MAXV  = 1023;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [CH_W-1:0]  in_ch;
  logic [WIDTH-1:0] in_data;
  logic             in_clr;
  logic             dump_req;
  logic             dump_clr;
  logic             out_valid;
  logic             out_ready;
  logic [CH_W-1:0]  out_ch;
  logic [ACC_W-1:0] out_data;
  logic             out_last;
  logic             busy;
  logic [NCH-1:0]   ovf;

  int compared   = 0;
  int mismatched = 0;

  int m_acc [NCH];
  bit m_ovf [NCH];

  accu_mc #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CH_W(CH_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data), .in_clr(in_clr),
    .dump_req(dump_req), .dump_clr(dump_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data),
    .out_last(out_last), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_ovf_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < NCH; i++) v[i] = m_ovf[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_acc[i] = 0;
      m_ovf[i] = 1'b0;
    end
  endtask

  task automatic model_apply(input int ch, input int d, input bit clr);
    int s;
    if (clr) begin
      m_acc[ch] = d;
      m_ovf[ch] = 1'b0;
    end else begin
      s = m_acc[ch] + d;
      if (s > MAXV) begin
        m_ovf[ch] = 1'b1;
`ifdef ACCU_SAT_EN
        m_acc[ch] = MAXV;
`else
        m_acc[ch] = s % (MAXV + 1);
`endif
      end else begin
        m_acc[ch] = s;
      end
    end
  endtask

  task automatic beat(input int ch, input int d, input bit clr);
    check("in_ready_idle", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_ch    = CH_W'(ch);
    in_data  = WIDTH'(d);
    in_clr   = clr;
    tick();
    in_valid = 1'b0;
    in_clr   = 1'b0;
    model_apply(ch, d, clr);
  endtask

  // Runs a full dump; stall0 holds the ch0 beat, other beats stall randomly up to stall_max.
  // While dumping, the input and dump_req lines are toggled randomly and must be ignored.
  task automatic dump(input bit clr, input int stall0, input int stall_max,
                      input bit wb, input int wch, input int wd);
    int stalls;
    check("pre_dump_out_valid", 32'(out_valid), 0);
    dump_req = 1'b1;
    dump_clr = clr;
    if (wb) begin
      in_valid = 1'b1;
      in_ch    = CH_W'(wch);
      in_data  = WIDTH'(wd);
      in_clr   = 1'b0;
    end
    tick();
    dump_req = 1'b0;
    dump_clr = 1'b0;
    in_valid = 1'b0;
    if (wb) model_apply(wch, wd, 1'b0);
    for (int c = 0; c < NCH; c++) begin
      stalls = (c == 0) ? stall0 : ((stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0);
      for (int s = 0; s <= stalls; s++) begin
        out_ready = (s == stalls);
        in_valid  = 1'($urandom_range(1, 0));
        in_ch     = CH_W'($urandom);
        in_data   = WIDTH'($urandom);
        dump_req  = 1'($urandom_range(1, 0));
        check("dump_out_valid", 32'(out_valid), 1);
        check("dump_busy", 32'(busy), 1);
        check("dump_in_ready", 32'(in_ready), 0);
        check("dump_out_ch", 32'(out_ch), c);
        check("dump_out_data", 32'(out_data), m_acc[c]);
        check("dump_out_last", 32'(out_last), (c == NCH - 1) ? 1 : 0);
        check("dump_ovf_bit", 32'(ovf[c]), 32'(m_ovf[c]));
        tick();
      end
      if (clr) begin
        m_acc[c] = 0;
        m_ovf[c] = 1'b0;
      end
    end
    in_valid  = 1'b0;
    dump_req  = 1'b0;
    out_ready = 1'b0;
    check("post_dump_busy", 32'(busy), 0);
    check("post_dump_in_ready", 32'(in_ready), 1);
    check("post_dump_out_valid", 32'(out_valid), 0);
    check("post_dump_out_last", 32'(out_last), 0);
    check("post_dump_out_ch", 32'(out_ch), 0);
    check("post_dump_ovf", 32'(ovf), model_ovf_vec());
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ch = '0; in_data = '0; in_clr = 1'b0;
    dump_req = 1'b0; dump_clr = 1'b0; out_ready = 1'b0;
    model_reset();
    #1;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_ch", 32'(out_ch), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ovf", 32'(ovf), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Empty dump straight after reset
    dump(1'b0, 0, 0, 1'b0, 0, 0);

    // Back-to-back beats to ch1
    beat(1, 200, 1'b0); beat(1, 200, 1'b0); beat(1, 200, 1'b0);
    check("ch1_sum_model", 32'(m_acc[1]), 600);
    dump(1'b1, 0, 0, 1'b0, 0, 0);

    // Overflow on ch2
    for (int i = 0; i < 5; i++) beat(2, 255, 1'b0);
    check("ovf2_idle", 32'(ovf), 32'h4);
    dump(1'b1, 0, 0, 1'b0, 0, 0);

    // Held beat with clearing dump, then a clean dump
    beat(0, 9, 1'b1);
    check("idle_out_data_ch0", 32'(out_data), 9);
    dump(1'b1, 3, 0, 1'b0, 0, 0);
    dump(1'b0, 0, 0, 1'b0, 0, 0);

    // Load overrides, then a beat in the same cycle as dump_req
    beat(0, 100, 1'b0);
    beat(0, 7, 1'b1);
    dump(1'b0, 0, 0, 1'b1, 3, 5);
    dump(1'b1, 0, 1, 1'b0, 0, 0);

    // Randomized traffic against the model
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 40; k++) begin
        if ($urandom_range(3, 0) == 0) tick();
        else beat(int'($urandom_range(NCH - 1, 0)), int'($urandom_range(255, 0)),
                  ($urandom_range(9, 0) == 0));
      end
      check("rand_idle_out_data", 32'(out_data), m_acc[0]);
      check("rand_idle_ovf", 32'(ovf), model_ovf_vec());
      dump(1'($urandom_range(1, 0)), int'($urandom_range(2, 0)), 2, 1'($urandom_range(1, 0)),
           int'($urandom_range(NCH - 1, 0)), int'($urandom_range(255, 0)));
    end

    // Reset mid-dump after two beats
    beat(3, 77, 1'b0);
    dump_req = 1'b1;
    tick();
    dump_req  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check("mid_dump_out_ch", 32'(out_ch), 2);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_in_ready", 32'(in_ready), 1);
    check("abort_ovf", 32'(ovf), 0);
    model_reset();
    out_ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    check("post_rst_in_ready", 32'(in_ready), 1);
    dump(1'b0, 0, 0, 1'b0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
